// File: rtl/req_arb_pkg.sv
// Shared types and default sizing for the request arbiter.
package req_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arbState_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;
    localparam int STALL_W     = 16;

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: lowest requesting index strictly after lastGrant, wrapping.
module rr_select import req_arb_pkg::*; #(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [ID_W-1:0]    lastGrant,
    output logic [ID_W-1:0]    index,
    output logic               found
);

    // candIdx[k] is the requester at rotational distance k+1 from lastGrant
    logic [ID_W-1:0] candIdx [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign candIdx[gi] = ID_W'((32'(lastGrant) + 32'(gi + 1)) % 32'(NUM_REQ));
    end

    always_comb begin
        index = '0;
        found = 1'b0;
        // Walk from the farthest candidate inward so the nearest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (reqVec[candIdx[k]]) begin
                index = candIdx[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// Packet-level round-robin arbiter: one owner holds the resource until its last
// beat or until it stalls for TIMEOUT cycles.
module req_arbiter import req_arb_pkg::*; #(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      res_valid,
    output logic [DATA_W-1:0]         res_data,
    output logic                      res_last,
    input  logic                      res_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    arbState_t          stateReg, stateNext;
    logic [ID_W-1:0]    grantReg, grantNext;
    logic [ID_W-1:0]    lastGrantReg, lastGrantNext;
    logic [STALL_W-1:0] stallCntReg, stallCntNext;
    logic               timeoutErrReg, timeoutErrNext;

    logic [ID_W-1:0]    selIdx;
    logic               selFound;
    logic               owning;
    logic               beatXfer;
    logic [DATA_W-1:0]  reqDataArr [NUM_REQ];

    rr_select #(.NUM_REQ(NUM_REQ)) u_rrSelect (
        .reqVec    (req_valid),
        .lastGrant (lastGrantReg),
        .index     (selIdx),
        .found     (selFound)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign reqDataArr[gi] = req_data[gi*DATA_W +: DATA_W];
        assign req_ready[gi]  = owning && (grantReg == ID_W'(gi)) && res_ready;
    end

    // Only the owner's lines reach the outputs; other requesters just feed selection.
    assign owning      = (stateReg == OWN);
    assign res_valid   = owning && req_valid[grantReg];
    assign res_data    = reqDataArr[grantReg];
    assign res_last    = owning && req_last[grantReg];
    assign beatXfer    = res_valid && res_ready;
    assign grant_id    = grantReg;
    assign busy        = owning;
    assign timeout_err = timeoutErrReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg      <= IDLE;
            grantReg      <= '0;
            lastGrantReg  <= ID_W'(NUM_REQ - 1);
            stallCntReg   <= '0;
            timeoutErrReg <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            grantReg      <= grantNext;
            lastGrantReg  <= lastGrantNext;
            stallCntReg   <= stallCntNext;
            timeoutErrReg <= timeoutErrNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        grantNext      = grantReg;
        lastGrantNext  = lastGrantReg;
        stallCntNext   = stallCntReg;
        timeoutErrNext = 1'b0;
        case (stateReg)
            IDLE: begin
                if (selFound) begin
                    grantNext    = selIdx;
                    stallCntNext = '0;
                    stateNext    = OWN;
                end
            end
            OWN: begin
                // A transfer always beats the stall limit when both land together.
                if (beatXfer) begin
                    stallCntNext = '0;
                    if (req_last[grantReg]) begin
                        stateNext     = RELEASE;
                        lastGrantNext = grantReg;
                    end
                end else if (stallCntReg == STALL_W'(TIMEOUT - 1)) begin
                    stateNext      = RELEASE;
                    lastGrantNext  = grantReg;
                    timeoutErrNext = 1'b1;
                end else begin
                    stallCntNext = stallCntReg + STALL_W'(1);
                end
            end
            RELEASE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed scenarios plus randomized traffic against a packet-level reference model.
module tb_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic            res_last;
    logic            res_ready = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    always #5 clk = ~clk;

    req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_last    (res_last),
        .res_ready   (res_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int testCnt = 0;
    int failCnt = 0;

    // Reference model: who owns the resource, who won last, stall cycles seen.
    int mOwner, mLast, mGrant, mStall;
    bit mReleasing, mPulse;

    // Packet sources: data byte = id*16 + beat number.
    int srcLen [N];
    int srcBeat [N];
    int beatsDone [N];
    bit srcEn [N];
    bit randLen;

    int cyc, busyCycles, toCount;
    bit prevBusy;
    int grantLog [$];
    int grantCyc [$];
    int xferLog [$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        mOwner = -1; mLast = N - 1; mGrant = 0; mStall = 0;
        mReleasing = 0; mPulse = 0;
    endtask

    task automatic modelAdvance();
        if (mReleasing) begin
            mReleasing = 0;
            mPulse = 0;
        end else if (mOwner < 0) begin
            for (int off = 1; off <= N; off++) begin
                int c;
                c = (mLast + off) % N;
                if (req_valid[c]) begin
                    mOwner = c; mGrant = c; mStall = 0;
                    break;
                end
            end
        end else begin
            if (req_valid[mOwner] && res_ready) begin
                mStall = 0;
                if (req_last[mOwner]) begin
                    mLast = mOwner; mOwner = -1; mReleasing = 1; mPulse = 0;
                end
            end else begin
                mStall++;
                if (mStall == TO) begin
                    mLast = mOwner; mOwner = -1; mReleasing = 1; mPulse = 1;
                end
            end
        end
    endtask

    task automatic checkOutputs();
        logic [N-1:0] expReady;
        bit own;
        own = (mOwner >= 0);
        expReady = '0;
        if (own) expReady[mOwner] = res_ready;
        checkVal("busy", busy, own);
        checkVal("grant_id", grant_id, mGrant);
        checkVal("res_valid", res_valid, own ? req_valid[mOwner] : 1'b0);
        checkVal("req_ready", req_ready, expReady);
        checkVal("timeout_err", timeout_err, mReleasing && mPulse);
        if (own) begin
            checkVal("res_data", res_data, req_data[mOwner*DW +: DW]);
            checkVal("res_last", res_last, req_last[mOwner]);
        end
    endtask

    task automatic driveSources();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = srcEn[i];
            req_last[i]  = (srcBeat[i] == srcLen[i] - 1);
            req_data[i*DW +: DW] = DW'(i * 16 + srcBeat[i]);
        end
    endtask

    task automatic srcUpdate();
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                beatsDone[i]++;
                if (req_last[i]) begin
                    srcBeat[i] = 0;
                    if (randLen) srcLen[i] = $urandom_range(1, 4);
                end else begin
                    srcBeat[i]++;
                end
            end
        end
    endtask

    task automatic observe();
        if (busy && !prevBusy) begin
            grantLog.push_back(int'(grant_id));
            grantCyc.push_back(cyc);
            $display("[TB] cyc %0d grant %0d", cyc, grant_id);
        end
        prevBusy = busy;
        if (busy) busyCycles++;
        if (timeout_err) toCount++;
        if (res_valid && res_ready) xferLog.push_back(int'(res_data));
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic tick();
        driveSources();
        #1;
        checkOutputs();
        observe();
        modelAdvance();
        srcUpdate();
        cyc++;
        @(negedge clk);
    endtask

    task automatic doReset(input bit midCycle);
        if (midCycle) #2;
        rst_n = 1'b0;
        modelReset();
        for (int i = 0; i < N; i++) begin
            srcEn[i] = 0; srcBeat[i] = 0; srcLen[i] = 1; beatsDone[i] = 0;
        end
        randLen = 0;
        res_ready = 1'b0;
        driveSources();
        #1;
        checkOutputs();
        @(negedge clk);
        checkOutputs();
        rst_n = 1'b1;
        cyc = 0; busyCycles = 0; toCount = 0; prevBusy = 0;
        grantLog.delete(); grantCyc.delete(); xferLog.delete();
    endtask

    initial begin
        int expOrder [5];
        int b1;
        int stallLeft;
        expOrder = '{0, 1, 2, 3, 0};
        cyc = 0;
        #2;
        @(negedge clk);

        // Single 3-beat packet from requester 0.
        doReset(0);
        srcLen[0] = 3; srcEn[0] = 1; res_ready = 1'b1;
        for (int k = 0; k < 20 && beatsDone[0] < 3; k++) tick();
        srcEn[0] = 0;
        checkVal("s1_beats", beatsDone[0], 3);
        checkVal("s1_busy_after_last", busy, 0);
        checkVal("s1_grant_cycle", grantCyc.size() > 0 ? grantCyc[0] : -1, 1);
        checkVal("s1_xfer_count", xferLog.size(), 3);
        for (int k = 0; k < 3; k++)
            checkVal("s1_beat_order", k < xferLog.size() ? xferLog[k] : -1, k);
        repeat (3) tick();

        // All four requesters with 1-beat packets continuously.
        doReset(0);
        for (int i = 0; i < N; i++) begin srcLen[i] = 1; srcEn[i] = 1; end
        res_ready = 1'b1;
        repeat (16) tick();
        checkVal("s2_grant_count", grantLog.size() >= 5, 1);
        for (int k = 0; k < 5 && k < grantLog.size(); k++)
            checkVal("s2_grant_order", grantLog[k], expOrder[k]);
        for (int k = 0; k < 4 && k + 1 < grantCyc.size(); k++)
            checkVal("s2_grant_spacing", grantCyc[k+1] - grantCyc[k], 3);

        // Owner 2 drops valid mid-packet while requester 1 keeps asking.
        doReset(0);
        srcLen[1] = 1; srcLen[2] = 3; srcEn[1] = 1; res_ready = 1'b1;
        for (int k = 0; k < 10 && beatsDone[1] < 1; k++) tick();
        srcEn[2] = 1;
        b1 = beatsDone[1];
        for (int k = 0; k < 10 && beatsDone[2] < 1; k++) tick();
        srcEn[2] = 0;
        repeat (5) begin
            tick();
            checkVal("s3_hold_grant", grant_id, 2);
            checkVal("s3_hold_busy", busy, 1);
        end
        srcEn[2] = 1;
        for (int k = 0; k < 10 && beatsDone[2] < 3; k++) tick();
        checkVal("s3_owner_beats", beatsDone[2], 3);
        checkVal("s3_no_interleave", beatsDone[1], b1);
        srcEn[2] = 0;
        for (int k = 0; k < 10 && beatsDone[1] == b1; k++) tick();
        checkVal("s3_next_grant", grantLog.size() > 0 ? grantLog[grantLog.size()-1] : -1, 1);

        // Owner 3 stalls until the timeout releases it.
        doReset(0);
        srcLen[3] = 2; srcEn[3] = 1; res_ready = 1'b0;
        for (int k = 0; k < 40 && toCount == 0; k++) tick();
        checkVal("s4_own_cycles", busyCycles, TO);
        srcLen[0] = 1; srcEn[0] = 1; res_ready = 1'b1;
        for (int k = 0; k < 10 && grantLog.size() < 2; k++) tick();
        checkVal("s4_timeout_pulses", toCount, 1);
        checkVal("s4_next_grant", grantLog.size() > 1 ? grantLog[1] : -1, 0);

        // Last beat accepted in the same cycle the stall limit is reached.
        doReset(0);
        srcLen[0] = 1; srcEn[0] = 1; res_ready = 1'b0;
        tick();
        repeat (TO - 1) tick();
        checkVal("s5_still_own", busy, 1);
        res_ready = 1'b1;
        tick();
        srcEn[0] = 0;
        repeat (2) tick();
        checkVal("s5_beat_taken", beatsDone[0], 1);
        checkVal("s5_no_timeout", toCount, 0);

        // Reset pulsed mid-packet from requester 1.
        doReset(0);
        srcLen[1] = 4; srcEn[1] = 1; res_ready = 1'b1;
        for (int k = 0; k < 10 && beatsDone[1] < 2; k++) tick();
        checkVal("s6_busy_before", busy, 1);
        doReset(1);
        srcLen[0] = 1; srcLen[1] = 4; srcEn[0] = 1; srcEn[1] = 1; res_ready = 1'b1;
        repeat (4) tick();
        checkVal("s6_next_grant", grantLog.size() > 0 ? grantLog[0] : -1, 0);
        checkVal("s6_no_timeout", toCount, 0);

        // Randomized traffic with bursts of resource back-pressure.
        doReset(0);
        randLen = 1;
        for (int i = 0; i < N; i++) srcLen[i] = $urandom_range(1, 4);
        stallLeft = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) srcEn[i] = ($urandom_range(0, 4) != 0);
            if (stallLeft > 0) begin
                res_ready = 1'b0;
                stallLeft--;
            end else if ($urandom_range(0, 19) == 0) begin
                stallLeft = $urandom_range(5, 14);
                res_ready = 1'b0;
            end else begin
                res_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
